// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared types and constants for the UART receive path.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Receiver frame-tracking states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // 16x oversampling, sampling on the 8th tick of each bit (mid-bit)
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    // One received character with its error flags
    typedef struct packed {
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } rx_word_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : Synchronous show-ahead FIFO of received words. A push into a
//             full FIFO is accepted only when a pop happens in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  logic     i_pop,
    input  rx_word_t i_wdata,
    output rx_word_t o_rdata,
    output logic     o_empty,
    output logic     o_full
);

    localparam int                PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  c_ptr_one = PTR_W'(1);
    localparam logic [PTR_W:0]    c_cnt_one = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]    c_cnt_max = (PTR_W + 1)'(DEPTH);

    rx_word_t          r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_cnt_max);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    // Head is gated to zero while empty so DATA reads back clean
    assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + c_ptr_one;
            if (w_do_pop)  r_rptr <= r_rptr + c_ptr_one;
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_core
//  Brief    : UART receive engine: rxd synchronizer, 16x tick generator,
//             deframing FSM and a show-ahead word FIFO with error flags.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV0  = 27,
    parameter int BAUD_DIV1  = 14,
    parameter int BAUD_DIV2  = 7,
    parameter int BAUD_DIV3  = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       ctrl_rxen,
    input  logic [1:0] ctrl_baud,
    input  logic       lpmode_en,
    input  logic [7:0] lpmode_div,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_ferr,
    output logic       rd_perr,
    output logic       stat_rxe,
    output logic       stat_busy,
    output logic       irq_rx,
    output logic       rx_ovf
);

    localparam int   SUB_W = $clog2(OVERSAMPLE);
    localparam logic c_odd = (PARITY_ODD != 0);

    logic             r_rxd_s1;
    logic             r_rxd_s2;
    logic             r_rxd_prev;
    logic [8:0]       w_div_sel;
    logic [8:0]       w_div_eff;
    logic [8:0]       r_div;
    logic [7:0]       r_tick_cnt;
    logic             w_tick;
    rx_state_t        r_state;
    logic [SUB_W-1:0] r_sub;
    logic [2:0]       r_bit;
    logic [7:0]       r_data;
    logic             r_perr;
    logic             r_push;
    rx_word_t         r_word;
    logic             w_sample;
    logic             w_start_edge;
    rx_word_t         w_head;
    logic             w_empty;
    logic             w_full;

    // Two-flop synchronizer plus one history flop for falling-edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_s1   <= 1'b1;
            r_rxd_s2   <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_s1   <= rxd;
            r_rxd_s2   <= r_rxd_s1;
            r_rxd_prev <= r_rxd_s2;
        end
    end

    // Requested divider; the effective one is only re-read at count 0 so a
    // change never truncates or stretches the tick period in progress
    always_comb begin
        w_div_sel = 9'(BAUD_DIV0);
        if (lpmode_en) begin
            w_div_sel = {1'b0, lpmode_div} + 9'd1;
        end else begin
            unique case (ctrl_baud)
                2'd0:    w_div_sel = 9'(BAUD_DIV0);
                2'd1:    w_div_sel = 9'(BAUD_DIV1);
                2'd2:    w_div_sel = 9'(BAUD_DIV2);
                default: w_div_sel = 9'(BAUD_DIV3);
            endcase
        end
        w_div_eff = (r_tick_cnt == 8'd0) ? w_div_sel : r_div;
    end

    assign w_tick = ctrl_rxen && ({1'b0, r_tick_cnt} == (w_div_eff - 9'd1));

    // 16x tick counter, parked at 0 while the receiver is disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= 8'd0;
            r_div      <= 9'(BAUD_DIV0);
        end else begin
            r_div <= w_div_eff;
            if (!ctrl_rxen || w_tick) r_tick_cnt <= 8'd0;
            else                      r_tick_cnt <= r_tick_cnt + 8'd1;
        end
    end

    assign w_sample     = w_tick && (r_sub == SUB_W'(MID_SAMPLE));
    assign w_start_edge = r_rxd_prev && !r_rxd_s2;

    // Deframing FSM; the sub-bit counter free-runs on ticks once a start
    // edge is seen, so every bit is sampled 16 ticks after the previous one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sub   <= '0;
            r_bit   <= 3'd0;
            r_data  <= 8'd0;
            r_perr  <= 1'b0;
            r_push  <= 1'b0;
            r_word  <= '0;
        end else if (!ctrl_rxen) begin
            r_state <= IDLE;
            r_sub   <= '0;
            r_push  <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (w_tick) r_sub <= r_sub + SUB_W'(1);
            unique case (r_state)
                IDLE: begin
                    r_sub <= '0;
                    if (w_start_edge) r_state <= START;
                end
                START: begin
                    if (w_sample) begin
                        r_bit   <= 3'd0;
                        r_perr  <= 1'b0;
                        r_state <= r_rxd_s2 ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        r_data <= {r_rxd_s2, r_data[7:1]};
                        r_bit  <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (w_sample) begin
                        r_perr  <= ((^r_data) ^ r_rxd_s2) != c_odd;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_sample) begin
                        r_word.perr <= r_perr;
                        r_word.ferr <= !r_rxd_s2;
                        r_word.data <= r_data;
                        r_push      <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_push),
        .i_pop   (rd_en),
        .i_wdata (r_word),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign rx_ovf    = r_push && w_full && !rd_en;
    assign irq_rx    = r_push && !rx_ovf;
    assign rd_data   = w_head.data;
    assign rd_ferr   = w_head.ferr;
    assign rd_perr   = w_head.perr;
    assign stat_rxe  = w_empty;
    assign stat_busy = (r_state != IDLE);

endmodule
`default_nettype wire
